// File: rtl/sha_msg_schedule.sv
// SHA message-schedule stage: loads a 16-word block, then streams W_t with its
// round index to the round stage for SHA-1, SHA-224/256 and the SHA-512 family.

package sha;
    typedef logic [63:0] word_t;
    typedef enum logic [2:0] {
        SHA1       = 3'd0,
        SHA224     = 3'd1,
        SHA256     = 3'd2,
        SHA384     = 3'd3,
        SHA512     = 3'd4,
        SHA512_224 = 3'd5,
        SHA512_256 = 3'd6
    } mode_t;
endpackage

module sha_msg_schedule (
    input  logic             clk,
    input  logic             rst,
    input  sha::mode_t       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  sha::word_t       in_word,
    output logic             w_valid,
    input  logic             w_ready,
    output sha::word_t       w,
    output logic [6:0]       t,
    output logic [1:0]       ft,
    output logic             last,
    output logic             done
);
    import sha::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    mode_t      mode_q, mode_d;
    word_t      w_q, w_d;
    logic [6:0] t_q, t_d;
    logic [1:0] ft_q, ft_d;
    logic       last_q, last_d;
    logic       w_valid_q, w_valid_d;
    logic       done_q, done_d;

    // 16-entry circular buffer, read at four taps at once, so kept in flops
    word_t      buf_q [16];
    logic       buf_we;
    logic [3:0] buf_waddr;
    word_t      buf_wdata;

    function automatic logic is_32bit(input mode_t m);
        return (m == SHA1) || (m == SHA224) || (m == SHA256);
    endfunction

    function automatic logic [31:0] s0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] s1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [63:0] s0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
    endfunction

    function automatic logic [63:0] s1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
    endfunction

    mode_t      eff_mode;
    word_t      load_word;
    logic [6:0] t_next;
    logic [3:0] n_lo;
    logic [6:0] last_idx;
    word_t      w2, w7, w15, w16;
    logic [31:0] w3l, w8l, w14l, sha1_x;
    word_t      sched_word;

    // Mode comes straight from the port for the first word of a block
    assign eff_mode  = (state_q == IDLE) ? mode : mode_q;
    assign load_word = is_32bit(eff_mode) ? {32'b0, in_word[31:0]} : in_word;

    assign t_next   = t_q + 7'd1;
    assign n_lo     = t_next[3:0];
    assign last_idx = ((mode_q == SHA224) || (mode_q == SHA256)) ? 7'd63 : 7'd79;

    // Slot (n-k) mod 16 holds W[n-k]; slot n mod 16 still holds W[n-16]
    assign w2   = buf_q[n_lo - 4'd2];
    assign w7   = buf_q[n_lo - 4'd7];
    assign w15  = buf_q[n_lo - 4'd15];
    assign w16  = buf_q[n_lo];
    assign w3l  = buf_q[n_lo - 4'd3][31:0];
    assign w8l  = buf_q[n_lo - 4'd8][31:0];
    assign w14l = buf_q[n_lo - 4'd14][31:0];
    assign sha1_x = w3l ^ w8l ^ w14l ^ w16[31:0];

    always_comb begin
        sched_word = 64'b0;
        if (mode_q == SHA1) begin
            sched_word = {32'b0, sha1_x[30:0], sha1_x[31]};
        end else if (is_32bit(mode_q)) begin
            sched_word = {32'b0, s1_32(w2[31:0]) + w7[31:0] + s0_32(w15[31:0]) + w16[31:0]};
        end else begin
            sched_word = s1_64(w2) + w7 + s0_64(w15) + w16;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        w_d       = w_q;
        t_d       = t_q;
        ft_d      = ft_q;
        last_d    = last_q;
        w_valid_d = w_valid_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = cnt_q;
        buf_wdata = load_word;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d    = mode;
                    buf_we    = 1'b1;
                    buf_waddr = 4'd0;
                    cnt_d     = 4'd1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d   = RUN;
                        t_d       = 7'd0;
                        w_d       = buf_q[0];
                        ft_d      = 2'd0;
                        last_d    = 1'b0;
                        w_valid_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_ready) begin
                    if (last_q) begin
                        state_d   = IDLE;
                        w_valid_d = 1'b0;
                        last_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        t_d    = t_next;
                        last_d = (t_next == last_idx);
                        if (mode_q != SHA1) begin
                            ft_d = 2'd0;
                        end else if (t_next < 7'd20) begin
                            ft_d = 2'd0;
                        end else if (t_next < 7'd40) begin
                            ft_d = 2'd1;
                        end else if (t_next < 7'd60) begin
                            ft_d = 2'd2;
                        end else begin
                            ft_d = 2'd3;
                        end
                        if (t_next < 7'd16) begin
                            w_d = buf_q[n_lo];
                        end else begin
                            w_d       = sched_word;
                            buf_we    = 1'b1;
                            buf_waddr = n_lo;
                            buf_wdata = sched_word;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            mode_q    <= SHA1;
            w_q       <= 64'b0;
            t_q       <= 7'd0;
            ft_q      <= 2'd0;
            last_q    <= 1'b0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            w_q       <= w_d;
            t_q       <= t_d;
            ft_q      <= ft_d;
            last_q    <= last_d;
            w_valid_q <= w_valid_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_waddr] <= buf_wdata;
        end
    end

    assign in_ready = (state_q != RUN);
    assign w_valid  = w_valid_q;
    assign w        = w_q;
    assign t        = t_q;
    assign ft       = ft_q;
    assign last     = last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: "abc" vectors for SHA-256/SHA-1/SHA-512,
// back-pressure, reset mid-run and back-to-back blocks, against a flat W[0..79] model.

module tb_sha_msg_schedule;
    import sha::*;

    logic       clk = 1'b0;
    logic       rst;
    mode_t      mode;
    logic       in_valid;
    logic       in_ready;
    word_t      in_word;
    logic       w_valid;
    logic       w_ready;
    word_t      w;
    logic [6:0] t;
    logic [1:0] ft;
    logic       last;
    logic       done;

    always #5 clk = ~clk;

    sha_msg_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w        (w),
        .t        (t),
        .ft       (ft),
        .last     (last),
        .done     (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    word_t      blk [16];
    word_t      exp_w [80];
    word_t      cap_w [4][80];
    logic [1:0] cap_ft [4][80];
    logic       cap_last [4][80];

    typedef struct {
        string      name;
        int         run;
        int         tt;
        logic       chk_w;
        word_t      w;
        logic [1:0] ft;
        logic       last;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nrounds(input mode_t m);
        return ((m == SHA224) || (m == SHA256)) ? 64 : 80;
    endfunction

    function automatic logic is32(input mode_t m);
        return (m == SHA1) || (m == SHA224) || (m == SHA256);
    endfunction

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference schedule computed over a flat 80-entry array
    task automatic build_model(input mode_t m);
        word_t       x [80];
        logic [31:0] a, s0, s1;
        logic [63:0] s0l, s1l;
        for (int i = 0; i < 16; i++)
            x[i] = is32(m) ? {32'b0, blk[i][31:0]} : blk[i];
        for (int i = 16; i < 80; i++) begin
            if (m == SHA1) begin
                a    = x[i-3][31:0] ^ x[i-8][31:0] ^ x[i-14][31:0] ^ x[i-16][31:0];
                x[i] = {32'b0, r32(a, 31)};
            end else if (is32(m)) begin
                s0   = r32(x[i-15][31:0], 7) ^ r32(x[i-15][31:0], 18) ^ (x[i-15][31:0] >> 3);
                s1   = r32(x[i-2][31:0], 17) ^ r32(x[i-2][31:0], 19) ^ (x[i-2][31:0] >> 10);
                x[i] = {32'b0, s1 + x[i-7][31:0] + s0 + x[i-16][31:0]};
            end else begin
                s0l  = r64(x[i-15], 1) ^ r64(x[i-15], 8) ^ (x[i-15] >> 7);
                s1l  = r64(x[i-2], 19) ^ r64(x[i-2], 61) ^ (x[i-2] >> 6);
                x[i] = s1l + x[i-7] + s0l + x[i-16];
            end
        end
        for (int i = 0; i < 80; i++) exp_w[i] = x[i];
    endtask

    task automatic set_abc(input logic wide);
        for (int i = 0; i < 16; i++) blk[i] = 64'b0;
        blk[0]  = wide ? 64'h6162638000000000 : 64'h0000000061626380;
        blk[15] = 64'h18;
    endtask

    // Other words carry a wrong mode on the port: only the first word's mode counts
    task automatic load_block(input mode_t m, input int start);
        int ready_err = 0;
        for (int i = start; i < 16; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) ready_err++;
            in_valid = 1'b1;
            in_word  = blk[i];
            mode     = (i == 0) ? m : ((m == SHA384) ? SHA1 : SHA384);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 64'b0;
        check("load_in_ready", 64'(ready_err), 64'd0);
        check("load_w_valid", 64'(w_valid), 64'd1);
        check("load_t0", 64'(t), 64'd0);
    endtask

    task automatic collect(input string name, input int run, input mode_t m, input int ready_pct,
                           input int abort_t, input logic hold_next, input mode_t next_mode);
        int         cycles = 0;
        int         hs = 0, dn = 0, seq_err = 0, stall_err = 0, iready_err = 0;
        logic       timed_out = 1'b0, stalled = 1'b0, wv_at_done = 1'b1;
        word_t      pw = 64'b0;
        logic [6:0] pt = 7'd0;
        int         n = nrounds(m);
        if (hold_next) begin
            in_valid = 1'b1;
            in_word  = blk[0];
            mode     = next_mode;
        end
        forever begin
            if (cycles >= 1000) begin
                timed_out = 1'b1;
                break;
            end
            if (done) begin
                dn++;
                wv_at_done = w_valid | last;
                if (hold_next && !in_ready) iready_err++;
                break;
            end
            if (w_valid) begin
                if (hold_next && in_ready) iready_err++;
                if (stalled && ((w !== pw) || (t !== pt))) stall_err++;
                if (abort_t >= 0 && int'(t) == abort_t) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check({name, "_rst_w_valid"}, 64'(w_valid), 64'd0);
                    check({name, "_rst_in_ready"}, 64'(in_ready), 64'd1);
                    check({name, "_rst_t"}, 64'(t), 64'd0);
                    check({name, "_rst_w"}, w, 64'd0);
                    check({name, "_rst_last_done"}, {62'b0, last, done}, 64'd0);
                    rst = 1'b0;
                    return;
                end
                w_ready = ($urandom_range(99) < ready_pct);
                if (w_ready) begin
                    if (int'(t) != hs) seq_err++;
                    if (hs < 80) begin
                        cap_w[run][hs]    = w;
                        cap_ft[run][hs]   = ft;
                        cap_last[run][hs] = last;
                        if (w !== exp_w[hs]) seq_err++;
                        if (last !== (hs == n - 1)) seq_err++;
                    end
                    hs++;
                end
                stalled = !w_ready;
                pw      = w;
                pt      = t;
            end else begin
                w_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            cycles++;
        end
        w_ready = 1'b0;
        if (!hold_next) in_valid = 1'b0;
        $display("%s: %0d handshakes, %0d done pulses, %0d sequence errors, %0d stall errors",
                 name, hs, dn, seq_err, stall_err);
        check({name, "_timeout"}, 64'(timed_out), 64'd0);
        check({name, "_handshakes"}, 64'(hs), 64'(n));
        check({name, "_done_count"}, 64'(dn), 64'd1);
        check({name, "_seq_errors"}, 64'(seq_err), 64'd0);
        check({name, "_stall_errors"}, 64'(stall_err), 64'd0);
        check({name, "_done_wvalid_last"}, 64'(wv_at_done), 64'd0);
        if (hold_next) check({name, "_in_ready_run"}, 64'(iready_err), 64'd0);
    endtask

    initial begin
        int diff;

        vecs[0]  = '{"sha256_t0",  0,  0, 1'b1, 64'h61626380, 2'd0, 1'b0};
        vecs[1]  = '{"sha256_t16", 0, 16, 1'b1, 64'h61626380, 2'd0, 1'b0};
        vecs[2]  = '{"sha256_t17", 0, 17, 1'b1, 64'h000F0000, 2'd0, 1'b0};
        vecs[3]  = '{"sha256_t63", 0, 63, 1'b0, 64'h0,        2'd0, 1'b1};
        vecs[4]  = '{"sha1_t16",   1, 16, 1'b1, 64'hC2C4C700, 2'd0, 1'b0};
        vecs[5]  = '{"sha1_t17",   1, 17, 1'b1, 64'h00000000, 2'd0, 1'b0};
        vecs[6]  = '{"sha1_t18",   1, 18, 1'b1, 64'h00000030, 2'd0, 1'b0};
        vecs[7]  = '{"sha1_t19",   1, 19, 1'b1, 64'h85898E01, 2'd0, 1'b0};
        vecs[8]  = '{"sha1_t20",   1, 20, 1'b0, 64'h0,        2'd1, 1'b0};
        vecs[9]  = '{"sha1_t79",   1, 79, 1'b0, 64'h0,        2'd3, 1'b1};
        vecs[10] = '{"sha512_t0",  2,  0, 1'b1, 64'h6162638000000000, 2'd0, 1'b0};
        vecs[11] = '{"sha512_t16", 2, 16, 1'b1, 64'h6162638000000000, 2'd0, 1'b0};
        vecs[12] = '{"sha512_t17", 2, 17, 1'b1, 64'h00030000000000C0, 2'd0, 1'b0};
        vecs[13] = '{"sha512_t79", 2, 79, 1'b0, 64'h0,        2'd0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = 64'b0;
        mode     = SHA256;
        w_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_w_valid", 64'(w_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_t", 64'(t), 64'd0);
        check("reset_w", w, 64'd0);
        check("reset_ft_last_done", {60'b0, ft, last, done}, 64'd0);
        rst = 1'b0;

        set_abc(1'b0); build_model(SHA256); load_block(SHA256, 0);
        collect("sha256", 0, SHA256, 100, -1, 1'b0, SHA1);
        @(negedge clk);
        check("sha256_done_pulse_width", 64'(done), 64'd0);

        set_abc(1'b0); build_model(SHA1); load_block(SHA1, 0);
        collect("sha1", 1, SHA1, 100, -1, 1'b0, SHA1);

        set_abc(1'b1); build_model(SHA512); load_block(SHA512, 0);
        collect("sha512", 2, SHA512, 100, -1, 1'b0, SHA1);

        set_abc(1'b0); build_model(SHA256); load_block(SHA256, 0);
        collect("backpressure", 3, SHA256, 30, -1, 1'b0, SHA1);
        diff = 0;
        for (int i = 0; i < 64; i++) if (cap_w[3][i] !== cap_w[0][i]) diff++;
        check("backpressure_vs_ready_run", 64'(diff), 64'd0);

        load_block(SHA256, 0);
        collect("reset_mid_run", 3, SHA256, 100, 30, 1'b0, SHA1);
        load_block(SHA256, 0);
        collect("after_reset", 3, SHA256, 100, -1, 1'b0, SHA1);

        load_block(SHA256, 0);
        collect("b2b_block1", 3, SHA256, 100, -1, 1'b1, SHA1);
        build_model(SHA1);
        load_block(SHA1, 1);
        collect("b2b_block2", 3, SHA1, 100, -1, 1'b0, SHA1);

        for (int i = 0; i < 14; i++) begin
            $display("vector %s: t=%0d w=0x%0h ft=%0d last=%0d", vecs[i].name, vecs[i].tt,
                     cap_w[vecs[i].run][vecs[i].tt], cap_ft[vecs[i].run][vecs[i].tt],
                     cap_last[vecs[i].run][vecs[i].tt]);
            if (vecs[i].chk_w)
                check({vecs[i].name, "_w"}, cap_w[vecs[i].run][vecs[i].tt], vecs[i].w);
            check({vecs[i].name, "_ft"}, 64'(cap_ft[vecs[i].run][vecs[i].tt]), 64'(vecs[i].ft));
            check({vecs[i].name, "_last"}, 64'(cap_last[vecs[i].run][vecs[i].tt]), 64'(vecs[i].last));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
